// File: rtl/spi_resp_pkg.sv
// Shared types and command-byte field positions for the SPI responder.
package spi_resp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StWr,
    StRd
  } state_e;

  // Command byte layout: addr in [7:3], direction in [1] (1 = write), [2] and [0] unused.
  localparam int unsigned CMD_ADDR_MSB = 7;
  localparam int unsigned CMD_ADDR_LSB = 3;
  localparam int unsigned CMD_DIR_BIT  = 1;

  localparam logic [4:0] STATUS_ADDR_DEF = 5'd25;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser with a third history stage for edge detection.
module sync_edge_det #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  // sync_q[1] is the synchronised level, sync_q[2] its previous value.
  logic [2:0] sync_q;

  // Shift the asynchronous input through the three stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {3{ResetVal}};
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign q_o    = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder exposing a register file with a MAX3421E-style command byte,
// plus a parallel local port onto the same registers.
module spi_responder
  import spi_resp_pkg::*;
#(
  parameter int unsigned NREG        = 32,
  parameter logic [4:0]  STATUS_ADDR = STATUS_ADDR_DEF,
  parameter logic [7:0]  RESET_VAL   = 8'h00
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     spi_ss_n,
  input  logic                     spi_sclk,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  input  logic                     lcl_we,
  input  logic [$clog2(NREG)-1:0]  lcl_addr,
  input  logic [7:0]               lcl_wdata,
  output logic [7:0]               lcl_rdata,
  output logic                     wr_strobe,
  output logic [$clog2(NREG)-1:0]  wr_addr,
  output logic [7:0]               wr_data,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(NREG);

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return 32'(a) < NREG;
  endfunction

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  // SS_n idles high so no spurious select is seen coming out of reset.
  sync_edge_det #(.ResetVal(1'b1)) u_sync_ss (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (spi_ss_n),
    .q_o    (ss_lvl),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  sync_edge_det #(.ResetVal(1'b0)) u_sync_sclk (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (spi_sclk),
    .q_o    (sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // MOSI has the same latency as SCLK, so q_o lines up with sclk_rise.
  sync_edge_det #(.ResetVal(1'b0)) u_sync_mosi (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (spi_mosi),
    .q_o    (mosi_s),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{ss_lvl, sclk_lvl, mosi_rise, mosi_fall};

  logic [7:0]    regs_q [NREG];
  state_e        state_q, state_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          miso_q, miso_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          strobe_q, strobe_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    lcl_rdata_q;

  logic [7:0]    rx_byte;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_rd_data;
  logic [7:0]    burst_rd_data;

  assign rx_byte       = {rx_q[6:0], mosi_s};
  assign cmd_addr      = rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
  assign cmd_rd_data   = addr_ok(cmd_addr) ? regs_q[cmd_addr] : 8'h00;
  assign burst_rd_data = addr_ok(addr_q) ? regs_q[addr_q] : 8'h00;

  // Next-state logic for the transaction FSM, shifters and commit pulse.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (ss_rise) begin
      // Deselect aborts from any state; a partial byte is thrown away.
      state_d = StIdle;
      rx_d    = 8'h00;
      cnt_d   = 3'd0;
      miso_d  = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ss_fall) begin
            state_d = StCmd;
            miso_d  = regs_q[STATUS_ADDR][7];
            tx_d    = {regs_q[STATUS_ADDR][6:0], 1'b0};
            rx_d    = 8'h00;
            cnt_d   = 3'd0;
            oe_d    = 1'b1;
            busy_d  = 1'b1;
          end
        end
        default: begin
          if (sclk_rise) begin
            rx_d  = rx_byte;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == StCmd) begin
                addr_d = cmd_addr;
                if (rx_byte[CMD_DIR_BIT]) begin
                  state_d = StWr;
                end else begin
                  state_d = StRd;
                  tx_d    = cmd_rd_data;
                end
              end else if (state_q == StWr) begin
                strobe_d  = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = rx_byte;
              end else begin
                // Re-read every byte so local updates show from the next byte on.
                tx_d = burst_rd_data;
              end
            end
          end else if (sclk_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
      endcase
    end
  end

  // Transaction state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      tx_q      <= 8'h00;
      rx_q      <= 8'h00;
      cnt_q     <= 3'd0;
      addr_q    <= '0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      strobe_q  <= strobe_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Register file: SPI commit in the strobe cycle beats a same-address local write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= RESET_VAL;
      end
      lcl_rdata_q <= 8'h00;
    end else begin
      if (strobe_q && addr_ok(wr_addr_q)) begin
        regs_q[wr_addr_q] <= wr_data_q;
      end
      if (lcl_we && addr_ok(lcl_addr) && !(strobe_q && (lcl_addr == wr_addr_q))) begin
        regs_q[lcl_addr] <= lcl_wdata;
      end
      lcl_rdata_q <= addr_ok(lcl_addr) ? regs_q[lcl_addr] : 8'h00;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign busy        = busy_q;
  assign wr_strobe   = strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign lcl_rdata   = lcl_rdata_q;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: local-port vector table plus SPI sequences.
module tb_spi_responder;

  localparam int HALF = 8;  // SCLK half period in clk cycles

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_ss_n = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       lcl_we = 1'b0;
  logic [4:0] lcl_addr = 5'd0;
  logic [7:0] lcl_wdata = 8'h00;
  logic [7:0] lcl_rdata;
  logic       wr_strobe;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  spi_responder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi_ss_n   (spi_ss_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .lcl_we     (lcl_we),
    .lcl_addr   (lcl_addr),
    .lcl_wdata  (lcl_wdata),
    .lcl_rdata  (lcl_rdata),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Strobe log, sampled mid-cycle.
  int         strb_cnt = 0;
  logic [4:0] log_addr [16];
  logic [7:0] log_data [16];

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      if (strb_cnt < 16) begin
        log_addr[strb_cnt] = wr_addr;
        log_data[strb_cnt] = wr_data;
      end
      strb_cnt = strb_cnt + 1;
    end
  end

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } lvec_t;

  lvec_t      lv [10];
  logic [7:0] tx_bytes [8];
  logic [7:0] rx_bytes [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lcl_read(input logic [4:0] a, output logic [7:0] d);
    lcl_we   = 1'b0;
    lcl_addr = a;
    clks(1);
    d = lcl_rdata;
  endtask

  // Master shifts nb bits of b MSB-first, capturing MISO at each rising edge.
  task automatic spi_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nb; i++) begin
      spi_mosi = b[3'(7 - i)];
      clks(HALF);
      spi_sclk = 1'b1;
      r = {r[6:0], spi_miso};
      clks(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_xfer(input int n);
    logic [7:0] r;
    spi_ss_n = 1'b0;
    clks(HALF);
    for (int k = 0; k < n; k++) begin
      spi_bits(tx_bytes[k], 8, r);
      rx_bytes[k] = r;
    end
    clks(HALF);
    spi_ss_n = 1'b1;
    clks(HALF);
  endtask

  // Waits for a strobe and lands a local write in that same cycle.
  task automatic collide(input logic [4:0] a, input logic [7:0] d);
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (wr_strobe === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL collide_wait got no wr_strobe expected one");
    end else begin
      lcl_we    = 1'b1;
      lcl_addr  = a;
      lcl_wdata = d;
      @(posedge clk);
      #1;
      lcl_we = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    logic [7:0] r;
    int base;

    lv[0] = '{1'b1, 5'd3,  8'h3C, 8'h00};
    lv[1] = '{1'b1, 5'd25, 8'hA5, 8'h00};
    lv[2] = '{1'b0, 5'd3,  8'h00, 8'h3C};
    lv[3] = '{1'b0, 5'd25, 8'h00, 8'hA5};
    lv[4] = '{1'b1, 5'd3,  8'h11, 8'h00};
    lv[5] = '{1'b0, 5'd3,  8'h00, 8'h11};
    lv[6] = '{1'b1, 5'd31, 8'hFF, 8'h00};
    lv[7] = '{1'b0, 5'd31, 8'h00, 8'hFF};
    lv[8] = '{1'b0, 5'd0,  8'h00, 8'h00};
    lv[9] = '{1'b1, 5'd3,  8'h3C, 8'h00};

    // Reset state
    #5;
    chk("rst_miso", 32'(spi_miso), 32'd0);
    chk("rst_oe", 32'(spi_miso_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_rdata", 32'(lcl_rdata), 32'd0);
    clks(3);
    reset_n = 1'b1;
    clks(3);

    // Single SPI write: 8A (addr 17, write) then 5C
    base = strb_cnt;
    tx_bytes[0] = 8'h8A;
    tx_bytes[1] = 8'h5C;
    spi_xfer(2);
    chk("wr_strobe_cnt", 32'(strb_cnt - base), 32'd1);
    chk("wr_addr", 32'(log_addr[base]), 32'd17);
    chk("wr_data", 32'(log_data[base]), 32'h5C);
    chk("wr_status_miso", 32'(rx_bytes[0]), 32'h00);
    lcl_read(5'd17, rd);
    chk("wr_readback", 32'(rd), 32'h5C);

    // Local port vector table
    for (int i = 0; i < 10; i++) begin
      lcl_we    = lv[i].we;
      lcl_addr  = lv[i].addr;
      lcl_wdata = lv[i].wdata;
      clks(1);
      if (!lv[i].we) chk("lcl_rd", 32'(lcl_rdata), 32'(lv[i].exp));
    end
    lcl_we = 1'b0;

    // Read with status byte
    base = strb_cnt;
    tx_bytes[0] = 8'h18;
    tx_bytes[1] = 8'h00;
    spi_xfer(2);
    chk("rd_status", 32'(rx_bytes[0]), 32'hA5);
    chk("rd_data", 32'(rx_bytes[1]), 32'h3C);
    chk("rd_no_strobe", 32'(strb_cnt - base), 32'd0);

    // Burst write to addr 17
    base = strb_cnt;
    tx_bytes[0] = 8'h8A;
    tx_bytes[1] = 8'h11;
    tx_bytes[2] = 8'h22;
    tx_bytes[3] = 8'h33;
    spi_xfer(4);
    chk("burst_cnt", 32'(strb_cnt - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("burst_addr", 32'(log_addr[base + i]), 32'd17);
    end
    chk("burst_d0", 32'(log_data[base]), 32'h11);
    chk("burst_d1", 32'(log_data[base + 1]), 32'h22);
    chk("burst_d2", 32'(log_data[base + 2]), 32'h33);
    lcl_read(5'd17, rd);
    chk("burst_final", 32'(rd), 32'h33);

    // Abort after 5 data bits
    base = strb_cnt;
    spi_ss_n = 1'b0;
    clks(HALF);
    spi_bits(8'h8A, 8, r);
    spi_bits(8'h99, 5, r);
    chk("abort_busy_before", 32'(busy), 32'd1);
    spi_ss_n = 1'b1;
    clks(3);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_oe", 32'(spi_miso_oe), 32'd0);
    chk("abort_miso", 32'(spi_miso), 32'd0);
    clks(HALF);
    chk("abort_no_strobe", 32'(strb_cnt - base), 32'd0);
    lcl_read(5'd17, rd);
    chk("abort_reg", 32'(rd), 32'h33);

    // Collision, same address: SPI wins
    tx_bytes[0] = 8'h8A;
    tx_bytes[1] = 8'h5C;
    fork
      spi_xfer(2);
      collide(5'd17, 8'hFF);
    join
    lcl_read(5'd17, rd);
    chk("coll_same", 32'(rd), 32'h5C);

    // Collision, different address: both land
    tx_bytes[1] = 8'h6D;
    fork
      spi_xfer(2);
      collide(5'd4, 8'hFF);
    join
    lcl_read(5'd17, rd);
    chk("coll_diff_spi", 32'(rd), 32'h6D);
    lcl_read(5'd4, rd);
    chk("coll_diff_lcl", 32'(rd), 32'hFF);

    // Reset mid command byte
    lcl_read(5'd17, rd);
    spi_ss_n = 1'b0;
    clks(HALF);
    spi_bits(8'h8A, 3, r);
    chk("mid_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_oe", 32'(spi_miso_oe), 32'd0);
    chk("mid_rst_miso", 32'(spi_miso), 32'd0);
    chk("mid_rst_rdata", 32'(lcl_rdata), 32'd0);
    chk("mid_rst_wraddr", 32'(wr_addr), 32'd0);
    chk("mid_rst_wrdata", 32'(wr_data), 32'd0);
    spi_ss_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    clks(2);
    reset_n = 1'b1;
    clks(4);
    lcl_read(5'd17, rd);
    chk("mid_rst_reg", 32'(rd), 32'h00);
    base = strb_cnt;
    tx_bytes[0] = 8'h8A;
    tx_bytes[1] = 8'h77;
    spi_xfer(2);
    chk("post_rst_cnt", 32'(strb_cnt - base), 32'd1);
    chk("post_rst_data", 32'(log_data[base]), 32'h77);
    lcl_read(5'd17, rd);
    chk("post_rst_reg", 32'(rd), 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
